// File: rtl/baud_gen.sv
// Fractional NCO baud-rate generator: oversample, mid-bit and end-of-bit strobes,
// legacy 50% baud clock, run-time divisor reload and start-edge resync.
module baud_gen #(
  parameter int unsigned INT_W        = 16,
  parameter int unsigned FRAC_W       = 8,
  parameter int unsigned OVS          = 16,
  parameter int unsigned DEFAULT_INT  = 19,
  parameter int unsigned DEFAULT_FRAC = 136
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [INT_W-1:0]  cfg_int_i,
  input  logic [FRAC_W-1:0] cfg_frac_i,
  output logic              os_tick_o,
  output logic              baud_tick_o,
  output logic              mid_tick_o,
  output logic              baud_clk_o
);

  localparam int unsigned OS_W = $clog2(OVS);
  localparam logic [INT_W-1:0]  DEF_INT  = INT_W'(DEFAULT_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_FRAC);
  localparam logic [INT_W-1:0]  RST_CNT  = (DEF_INT < INT_W'(2)) ? INT_W'(1) : DEF_INT - INT_W'(1);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0]   OS_MID   = OS_W'(OVS / 2 - 1);

  logic [INT_W-1:0]  div_int, div_int_n;
  logic [FRAC_W-1:0] div_frac, div_frac_n;
  logic [INT_W-1:0]  pend_int, pend_int_n;
  logic [FRAC_W-1:0] pend_frac, pend_frac_n;
  logic              pend_v, pend_v_n;
  logic [INT_W-1:0]  cnt, cnt_n;
  logic [FRAC_W-1:0] acc, acc_n;
  logic [OS_W-1:0]   os_cnt, os_cnt_n;
  logic              baud_clk, baud_clk_n;

  logic              boundary, apply;
  logic [INT_W-1:0]  new_int, eff;
  logic [FRAC_W-1:0] new_frac, acc_base;
  logic [FRAC_W:0]   sum;
  logic [INT_W:0]    reload;
  logic [INT_W-1:0]  reload_sat;

  // Next-state: disable > resync > boundary > decrement; pending divisor rides along.
  always_comb begin
    div_int_n   = div_int;
    div_frac_n  = div_frac;
    pend_int_n  = pend_int;
    pend_frac_n = pend_frac;
    pend_v_n    = pend_v;
    cnt_n       = cnt;
    acc_n       = acc;
    os_cnt_n    = os_cnt;
    baud_clk_n  = baud_clk;

    boundary   = en_i & ~sync_i & (cnt == '0);
    apply      = pend_v & (~en_i | sync_i | boundary);
    new_int    = apply ? pend_int : div_int;
    new_frac   = apply ? pend_frac : div_frac;
    eff        = (new_int < INT_W'(2)) ? INT_W'(2) : new_int;
    acc_base   = apply ? '0 : acc;
    sum        = (FRAC_W + 1)'(acc_base) + (FRAC_W + 1)'(new_frac);
    reload     = (INT_W + 1)'(eff) - (INT_W + 1)'(1) + (INT_W + 1)'(sum[FRAC_W]);
    reload_sat = reload[INT_W] ? '1 : reload[INT_W-1:0];

    div_int_n  = new_int;
    div_frac_n = new_frac;
    if (apply) begin
      pend_v_n = 1'b0;
    end else if (cfg_valid_i && !pend_v) begin
      pend_v_n    = 1'b1;
      pend_int_n  = cfg_int_i;
      pend_frac_n = cfg_frac_i;
    end

    if (!en_i || sync_i) begin
      cnt_n      = eff - INT_W'(1);
      acc_n      = '0;
      os_cnt_n   = '0;
      baud_clk_n = 1'b0;
    end else if (boundary) begin
      cnt_n    = reload_sat;
      acc_n    = sum[FRAC_W-1:0];
      os_cnt_n = (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      if (os_cnt == OS_LAST || os_cnt == OS_MID) baud_clk_n = ~baud_clk;
    end else begin
      cnt_n = cnt - INT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_int   <= DEF_INT;
      div_frac  <= DEF_FRAC;
      pend_int  <= '0;
      pend_frac <= '0;
      pend_v    <= 1'b0;
      cnt       <= RST_CNT;
      acc       <= '0;
      os_cnt    <= '0;
      baud_clk  <= 1'b0;
    end else begin
      div_int   <= div_int_n;
      div_frac  <= div_frac_n;
      pend_int  <= pend_int_n;
      pend_frac <= pend_frac_n;
      pend_v    <= pend_v_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      os_cnt    <= os_cnt_n;
      baud_clk  <= baud_clk_n;
    end
  end

  // Strobes decode the boundary cycle directly so they line up with cnt==0.
  assign os_tick_o   = boundary;
  assign baud_tick_o = boundary & (os_cnt == OS_LAST);
  assign mid_tick_o  = boundary & (os_cnt == OS_MID);
  assign baud_clk_o  = baud_clk;
  assign cfg_ready_o = ~pend_v;

endmodule
